sram_periph_resp: RTL and testbench
===================================

# sram_periph_resp

Memory-mapped peripheral responder on the CPU's data SRAM-like bus, sitting beside the data RAM after MMU translation. It decodes a physical address window and serves single-cycle-latency reads and byte-masked writes to scratch, timer/compare, interrupt, LED, switch and numeric-display registers. It generates the timer interrupt that feeds one bit of the CPU's `int` input. The top level uses `hit_o` to choose between its read data and the RAM's.

## Interface
- `BASE_ADDR`, 32'h1FAF_0000: physical window base; a hit is `addr_i[31:16] == BASE_ADDR[31:16]`.
- `SW_W`, 8: switch input width.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `en_i` in 1: access request this cycle (`data_sram_en`).
- `wen_i` in 4: byte write enables; 0000 means read (`data_sram_wen`).
- `addr_i` in 32: physical byte address; bits [1:0] are ignored.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, valid the cycle after the request.
- `hit_o` out 1: registered; the previous cycle's request fell in the window.
- `switch_i` in SW_W: asynchronous board switches.
- `led_o` out 16: LED register.
- `num_o` out 32: numeric-display register.
- `timer_int_o` out 1: timer interrupt, level.

## Operation
Register map, offset = `addr_i[15:0]`; unlisted offsets read 0 and ignore writes:
- 0x00 SCRATCH0 RW, 0x04 SCRATCH1 RW: full 32-bit, byte-maskable.
- 0x10 TIMER RW:
  - Increments by 1 per cycle when CTRL.en = 1; wraps 0xFFFF_FFFF→0.
  - A write loads the byte-merged value and takes precedence over that cycle's increment.
- 0x14 COMPARE RW, byte-maskable. Any write to it clears the pending bit.
- 0x18 IRQ_STATUS:
  - bit0 = pending; other bits read 0.
  - Writing 1 to bit0 (with `wen_i[0]` set) clears it; writing 0 has no effect.
- 0x1C CTRL RW: bit0 = en (timer counting), bit1 = ie (interrupt enable); other bits read 0.
- 0x20 LED RW: bits [15:0] drive `led_o`; bits [31:16] read 0.
- 0x24 SWITCH RO: two-flop synchronized `switch_i`, zero-extended.
- 0x28 NUM RW: 32-bit, drives `num_o`.

Rules:
- Writes commit at the rising edge that ends the request cycle.
- Each byte of a register is updated only when its `wen_i` bit is set.
- Pending bit:
  - Set at the edge after the cycle where CTRL.en = 1 and TIMER == COMPARE.
  - If a set and a clear (COMPARE write or IRQ_STATUS clear) occur in the same cycle, set wins.
- `timer_int_o` = pending & CTRL.ie, driven from flops only.
- A request with `en_i` = 0 or outside the window has no side effects. On the next cycle, `hit_o` = 0 and `rdata_o` = 0.

## Timing
- Read latency is 1 cycle:
  - The request is sampled at edge N.
  - `rdata_o` and `hit_o` are valid after edge N and hold until the next edge.
  - `rdata_o` is registered.
- TIMER read value is the counter value present during the request cycle, before that edge's increment.
- Write followed by read of the same register on the next cycle returns the new value. Back-to-back requests are accepted every cycle; there is no stall.
- A write request also produces `hit_o` = 1 on the next cycle, with `rdata_o` = the pre-write value (don't-care to the CPU).
- Switch path latency is 2 cycles of synchronization plus 1 cycle of read.
- Reset values:
  - `rdata_o` = 0, `hit_o` = 0, `led_o` = 0, `num_o` = 0, `timer_int_o` = 0.
  - SCRATCH = 0, TIMER = 0, COMPARE = 0xFFFF_FFFF, pending = 0.
  - CTRL = 0x1 (counting, interrupt disabled); synchronizer flops = 0.
- Reset asserted mid-operation forces all of the above immediately (asynchronous). Deassertion is treated as synchronous to `clk` by the top level.

## Structure
- Shared package `periph_pkg`:
  - Register offset constants (`OFF_SCRATCH0` … `OFF_NUM`).
  - CTRL bit indices.
  - Reset constants: `COMPARE_RST`, `CTRL_RST`.
  - A byte-merge function taking (old, new, wen).
- One sub-module, `periph_timer`, contains TIMER, COMPARE, pending, the set/clear priority, and the increment/load rule. It exposes load/write strobes and the value buses.
- Address decode, the other registers, the synchronizer and the read mux live in `sram_periph_resp`.

## Test plan
- Reset, then a read of 0x1FAF_001C → next cycle `hit_o` = 1, `rdata_o` = 0x1. A read of 0x1FAF_0014 → 0xFFFF_FFFF.
- Write 0xDEADBEEF to 0x00 with wen 1111, then write 0x11223344 with wen 0101, then read → 0xDE22BE44. Read of 0x1FAF_0030 → `hit_o` = 1, 0. Read of 0x0000_0000 → `hit_o` = 0.
- Timer interrupt:
  - Write TIMER = 10, COMPARE = 15, CTRL = 3.
  - `timer_int_o` rises exactly 6 cycles after the TIMER write edge.
  - Writing 1 to IRQ_STATUS drops it the next edge.
- Collisions:
  - TIMER write of 0xFFFF_FFFF with CTRL.en = 1 → the following read returns 0x0000_0000 (wrap).
  - A COMPARE write in the same cycle as a match leaves pending = 1.
- Back-to-back: write LED = 0x0000A5A5 at cycle N, read LED at N+1 → `rdata_o` = 0x0000A5A5; `led_o` = 0xA5A5 from edge N.
- Assert `resetn` low mid-count with pending = 1 → `timer_int_o`, `led_o`, `num_o` and `hit_o` go to 0 without a clock edge. Setting `switch_i` = 0x3C after release → a read at 0x24 returns 0x3C once 2 synchronization cycles have elapsed.

Source files
------------

// File: rtl/periph_pkg.sv
// Shared constants and helpers for the SRAM-bus peripheral responder.
// Register offsets, CTRL bit positions, reset values and byte merge.
package periph_pkg;

  localparam logic [15:0] OFF_SCRATCH0 = 16'h0000;
  localparam logic [15:0] OFF_SCRATCH1 = 16'h0004;
  localparam logic [15:0] OFF_TIMER    = 16'h0010;
  localparam logic [15:0] OFF_COMPARE  = 16'h0014;
  localparam logic [15:0] OFF_IRQ      = 16'h0018;
  localparam logic [15:0] OFF_CTRL     = 16'h001C;
  localparam logic [15:0] OFF_LED      = 16'h0020;
  localparam logic [15:0] OFF_SWITCH   = 16'h0024;
  localparam logic [15:0] OFF_NUM      = 16'h0028;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  localparam logic [1:0]  CTRL_RST    = 2'b01;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  wen
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/periph_timer.sv
// Free-running timer with compare match and sticky pending flag.
// Bus writes override the increment; a match in the same cycle as a clear wins.
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_en,
  input  logic        timer_wr,
  input  logic        cmp_wr,
  input  logic        irq_clr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wen,
  output logic [31:0] timer,
  output logic [31:0] compare,
  output logic        pending
);

  logic match;
  logic clr;

  assign match = count_en && (timer == compare);
  assign clr   = cmp_wr || irq_clr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer   <= 32'h0;
      compare <= COMPARE_RST;
      pending <= 1'b0;
    end else begin
      if (timer_wr) begin
        timer <= byte_merge(timer, wdata, wen);
      end else if (count_en) begin
        timer <= timer + 32'd1;
      end
      if (cmp_wr) begin
        compare <= byte_merge(compare, wdata, wen);
      end
      pending <= match || (pending && !clr);
    end
  end

endmodule

// File: rtl/sram_periph_resp.sv
// Memory-mapped peripheral responder beside the data RAM.
// One-cycle registered read data; byte-masked writes commit at the request edge.
module sram_periph_resp
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1FAF_0000,
  parameter int          SW_W      = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en_i,
  input  logic [3:0]      wen_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            hit_o,
  input  logic [SW_W-1:0] switch_i,
  output logic [15:0]     led_o,
  output logic [31:0]     num_o,
  output logic            timer_int_o
);

  logic [15:0]     off;
  logic            acc;
  logic            wr;
  logic            unused_ok;

  logic            sel_s0;
  logic            sel_s1;
  logic            sel_tmr;
  logic            sel_cmp;
  logic            sel_irq;
  logic            sel_ctrl;
  logic            sel_led;
  logic            sel_sw;
  logic            sel_num;

  logic [31:0]     scratch0;
  logic [31:0]     scratch1;
  logic [1:0]      ctrl;
  logic [15:0]     led;
  logic [31:0]     num;
  logic [SW_W-1:0] sync1;
  logic [SW_W-1:0] sync2;

  logic [31:0]     timer;
  logic [31:0]     compare;
  logic            pending;
  logic [31:0]     rd_mux;

  assign off       = {addr_i[15:2], 2'b00};
  assign acc       = en_i && (addr_i[31:16] == BASE_ADDR[31:16]);
  assign wr        = acc && (wen_i != 4'b0000);
  assign unused_ok = ^addr_i[1:0];

  assign sel_s0   = off == OFF_SCRATCH0;
  assign sel_s1   = off == OFF_SCRATCH1;
  assign sel_tmr  = off == OFF_TIMER;
  assign sel_cmp  = off == OFF_COMPARE;
  assign sel_irq  = off == OFF_IRQ;
  assign sel_ctrl = off == OFF_CTRL;
  assign sel_led  = off == OFF_LED;
  assign sel_sw   = off == OFF_SWITCH;
  assign sel_num  = off == OFF_NUM;

  periph_timer u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .count_en (ctrl[CTRL_EN]),
    .timer_wr (wr && sel_tmr),
    .cmp_wr   (wr && sel_cmp),
    .irq_clr  (wr && sel_irq && wen_i[0] && wdata_i[0]),
    .wdata    (wdata_i),
    .wen      (wen_i),
    .timer    (timer),
    .compare  (compare),
    .pending  (pending)
  );

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      sel_s0:   rd_mux = scratch0;
      sel_s1:   rd_mux = scratch1;
      sel_tmr:  rd_mux = timer;
      sel_cmp:  rd_mux = compare;
      sel_irq:  rd_mux = {31'h0, pending};
      sel_ctrl: rd_mux = {30'h0, ctrl};
      sel_led:  rd_mux = {16'h0, led};
      sel_sw:   rd_mux = 32'(sync2);
      sel_num:  rd_mux = num;
      default:  rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_o  <= 32'h0;
      hit_o    <= 1'b0;
      scratch0 <= 32'h0;
      scratch1 <= 32'h0;
      ctrl     <= CTRL_RST;
      led      <= 16'h0;
      num      <= 32'h0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      rdata_o <= acc ? rd_mux : 32'h0;
      hit_o   <= acc;
      sync1   <= switch_i;
      sync2   <= sync1;
      if (wr && sel_s0) scratch0 <= byte_merge(scratch0, wdata_i, wen_i);
      if (wr && sel_s1) scratch1 <= byte_merge(scratch1, wdata_i, wen_i);
      if (wr && sel_num) num <= byte_merge(num, wdata_i, wen_i);
      if (wr && sel_ctrl && wen_i[0]) ctrl <= wdata_i[1:0];
      if (wr && sel_led && wen_i[0]) led[7:0] <= wdata_i[7:0];
      if (wr && sel_led && wen_i[1]) led[15:8] <= wdata_i[15:8];
    end
  end

  assign led_o       = led;
  assign num_o       = num;
  assign timer_int_o = pending && ctrl[CTRL_IE];

endmodule

// File: tb/tb_sram_periph_resp.sv
// Directed bench for sram_periph_resp with a register-map reference model.
// Outputs are compared against the model every cycle plus literal spot checks.
module tb_sram_periph_resp;

  logic        clk;
  logic        resetn;
  logic        en_i;
  logic [3:0]  wen_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        hit_o;
  logic [7:0]  switch_i;
  logic [15:0] led_o;
  logic [31:0] num_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  localparam logic [31:0] B = 32'h1FAF_0000;

  sram_periph_resp dut (
    .clk         (clk),
    .resetn      (resetn),
    .en_i        (en_i),
    .wen_i       (wen_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .hit_o       (hit_o),
    .switch_i    (switch_i),
    .led_o       (led_o),
    .num_o       (num_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // model state
  logic [31:0] m_reg [0:15];
  logic [31:0] m_timer, m_cmp;
  bit          m_pend, m_en, m_ie;
  logic [7:0]  m_s1, m_s2;
  logic [31:0] m_rdata;
  bit          m_hit;

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0, 1, 10: return m_reg[idx];
      4:  return m_timer;
      5:  return m_cmp;
      6:  return {31'h0, m_pend};
      7:  return {30'h0, m_ie, m_en};
      8:  return {16'h0, m_reg[8][15:0]};
      9:  return {24'h0, m_s2};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
      m_timer = 0; m_cmp = 32'hFFFF_FFFF; m_pend = 0;
      m_en = 1; m_ie = 0; m_s1 = 0; m_s2 = 0;
      m_rdata = 0; m_hit = 0;
    end else begin
      bit inwin, wr;
      int idx;
      bit match, clr, twr;
      logic [31:0] t;
      inwin = en_i && addr_i[31:16] == 16'h1FAF;
      idx = (addr_i[15:0] < 16'h0040) ? int'(addr_i[15:2]) : 99;
      wr = inwin && wen_i != 0;
      m_hit = inwin;
      m_rdata = inwin ? m_read(idx) : 32'h0;
      match = m_en && m_timer == m_cmp;
      clr = 0; twr = 0;
      m_s2 = m_s1; m_s1 = switch_i;
      if (wr) begin
        case (idx)
          0, 1, 10: for (int b = 0; b < 4; b++)
            if (wen_i[b]) m_reg[idx][8*b +: 8] = wdata_i[8*b +: 8];
          4: begin
            t = m_timer;
            for (int b = 0; b < 4; b++)
              if (wen_i[b]) t[8*b +: 8] = wdata_i[8*b +: 8];
            m_timer = t; twr = 1;
          end
          5: begin
            for (int b = 0; b < 4; b++)
              if (wen_i[b]) m_cmp[8*b +: 8] = wdata_i[8*b +: 8];
            clr = 1;
          end
          6: if (wen_i[0] && wdata_i[0]) clr = 1;
          7: if (wen_i[0]) begin m_en = wdata_i[0]; m_ie = wdata_i[1]; end
          8: for (int b = 0; b < 2; b++)
            if (wen_i[b]) m_reg[8][8*b +: 8] = wdata_i[8*b +: 8];
          default: ;
        endcase
      end
      if (!twr && match) m_timer = m_timer + 1;
      else if (!twr && m_en) m_timer = m_timer + 1;
      if (match) m_pend = 1;
      else if (clr) m_pend = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdata", rdata_o, m_rdata);
      chk("hit", {31'h0, hit_o}, {31'h0, m_hit});
      chk("led", {16'h0, led_o}, {16'h0, m_reg[8][15:0]});
      chk("num", num_o, m_reg[10]);
      chk("int", {31'h0, timer_int_o}, {31'h0, m_pend && m_ie});
    end
  end

  task automatic bus(input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en_i = e; wen_i = w; addr_i = a; wdata_i = d;
    @(posedge clk);
    @(negedge clk);
    en_i = 0; wen_i = 0;
  endtask

  task automatic idle();
    bus(0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    resetn = 0; en_i = 0; wen_i = 0; addr_i = 0; wdata_i = 0; switch_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_hit", {31'h0, hit_o}, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_num", num_o, 32'h0);
    chk("rst_int", {31'h0, timer_int_o}, 32'h0);
    resetn = 1;
    chk_on = 1;

    bus(1, 4'h0, B + 32'h1C, 0);
    chk("ctrl_rst", rdata_o, 32'h1);
    chk("ctrl_hit", {31'h0, hit_o}, 32'h1);
    bus(1, 4'h0, B + 32'h14, 0);
    chk("cmp_rst", rdata_o, 32'hFFFF_FFFF);

    bus(1, 4'hF, B + 32'h00, 32'hDEADBEEF);
    bus(1, 4'h5, B + 32'h00, 32'h11223344);
    bus(1, 4'h0, B + 32'h00, 0);
    chk("scratch_merge", rdata_o, 32'hDE22BE44);
    bus(1, 4'h0, B + 32'h30, 0);
    chk("unmapped_hit", {31'h0, hit_o}, 32'h1);
    chk("unmapped_data", rdata_o, 32'h0);
    bus(1, 4'h0, 32'h0000_0000, 0);
    chk("miss_hit", {31'h0, hit_o}, 32'h0);
    chk("miss_data", rdata_o, 32'h0);

    bus(1, 4'hF, B + 32'h10, 32'd10);
    bus(1, 4'hF, B + 32'h14, 32'd15);
    bus(1, 4'hF, B + 32'h1C, 32'd3);
    for (int k = 3; k <= 6; k++) begin
      idle();
      chk($sformatf("int_edge%0d", k), {31'h0, timer_int_o},
          (k == 6) ? 32'h1 : 32'h0);
    end
    bus(1, 4'h1, B + 32'h18, 32'h1);
    chk("int_clear", {31'h0, timer_int_o}, 32'h0);

    bus(1, 4'hF, B + 32'h10, 32'hFFFF_FFFF);
    idle();
    bus(1, 4'h0, B + 32'h10, 0);
    chk("timer_wrap", rdata_o, 32'h0);

    bus(1, 4'hF, B + 32'h10, 32'd50);
    bus(1, 4'hF, B + 32'h14, 32'd51);
    bus(1, 4'hF, B + 32'h14, 32'd0);
    chk("set_beats_clr_int", {31'h0, timer_int_o}, 32'h1);
    bus(1, 4'h0, B + 32'h18, 0);
    chk("set_beats_clr_st", rdata_o, 32'h1);
    bus(1, 4'h1, B + 32'h18, 32'h1);

    bus(1, 4'hF, B + 32'h20, 32'h0000_A5A5);
    chk("led_out", {16'h0, led_o}, 32'h0000_A5A5);
    bus(1, 4'h0, B + 32'h20, 0);
    chk("led_read", rdata_o, 32'h0000_A5A5);
    bus(1, 4'hF, B + 32'h28, 32'h1234_5678);
    chk("num_out", num_o, 32'h1234_5678);

    bus(1, 4'hF, B + 32'h10, 32'd7);
    bus(1, 4'hF, B + 32'h14, 32'd8);
    bus(1, 4'h0, B + 32'h1C, 0);
    chk("pre_rst_int", {31'h0, timer_int_o}, 32'h1);
    chk("pre_rst_hit", {31'h0, hit_o}, 32'h1);
    #2 resetn = 0;
    #1;
    chk("arst_int", {31'h0, timer_int_o}, 32'h0);
    chk("arst_led", {16'h0, led_o}, 32'h0);
    chk("arst_num", num_o, 32'h0);
    chk("arst_hit", {31'h0, hit_o}, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1;
    switch_i = 8'h3C;
    idle();
    idle();
    bus(1, 4'h0, B + 32'h24, 0);
    chk("switch_sync", rdata_o, 32'h0000_003C);

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
